serial_accum_ctrl: RTL and testbench

//  Bit-serial accumulator and sequencer that sits downstream of the 8:1 bit-select mux.

---
 rtl/serial_accum_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_accum_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_accum_ctrl.sv
// ----------------------------------------------------------------------------
// serial_accum_ctrl
//
// Bit-serial accumulator and sequencer placed behind an external 8:1
// bit-select mux. Each pass walks the mux select LSB-first. The bit that the
// mux returns on the same cycle is added into the matching accumulator bit.
// A single full adder is used, and the ripple carry is held in a flop between
// cycles. When the final bit has been written, the block raises a one-cycle
// done pulse and latches the carry-out of the pass.
//
// Ports
//   i_clk          in   1       rising-edge clock
//   i_rst_n        in   1       asynchronous active-low reset
//   i_start        in   1       start one accumulate pass (honoured in IDLE)
//   i_clear        in   1       zero accumulator and carry (IDLE, beats start)
//   o_con_choice   out  SEL_W   bit index driven to the mux select
//   i_data_swbit   in   1       selected operand bit back from the mux
//   o_acc          out  DATA_W  accumulator value (valid while o_done=1)
//   o_carry        out  1       carry-out of the most recent completed pass
//   o_busy         out  1       high while bits are being shifted
//   o_done         out  1       one-cycle pulse after the last bit is written
// ----------------------------------------------------------------------------
module serial_accum_ctrl #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_clear,
    output logic [SEL_W-1:0]  o_con_choice,
    input  logic              i_data_swbit,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_carry,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DATA_W - 1);

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic               carry_ff;
    logic [DATA_W-1:0]  acc_q;

    // One-bit full adder on the bit currently selected by the mux.
    logic bit_a;
    logic bit_b;
    logic sum_bit;
    logic carry_bit;

    always_comb begin
        bit_a     = i_data_swbit;
        bit_b     = acc_q[idx];
        sum_bit   = bit_a ^ bit_b ^ carry_ff;
        carry_bit = (bit_a & bit_b) | (bit_a & carry_ff) | (bit_b & carry_ff);
    end

    // idx is returned to zero on the last bit and on a start, so it reads 0 in
    // IDLE and DONE. That lets the registered idx drive the mux select directly.
    assign o_con_choice = idx;
    assign o_acc        = acc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry_ff <= 1'b0;
            acc_q    <= '0;
            o_carry  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    if (i_clear) begin
                        acc_q   <= '0;
                        o_carry <= 1'b0;
                    end else if (i_start) begin
                        idx      <= '0;
                        carry_ff <= 1'b0;
                        o_carry  <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end

                // Start and clear are deliberately not looked at here, so a
                // pass cannot be disturbed once it has begun.
                S_SHIFT: begin
                    acc_q[idx] <= sum_bit;
                    carry_ff   <= carry_bit;
                    if (idx == LAST_IDX) begin
                        o_carry <= carry_bit;
                        idx     <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    idx    <= '0;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_accum_ctrl
//
// Bench for serial_accum_ctrl. It models the 8:1 bit-select mux
// combinationally from a switch value. Each pass pushes its expected
// accumulator and carry to a queue, and the entry is popped and compared when
// o_done appears.
// ----------------------------------------------------------------------------
module tb_serial_accum_ctrl;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic [SEL_W-1:0]  con_choice;
    logic              data_swbit;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] sw = '0;

    // External mux: the select goes out and the chosen bit comes back on the same cycle.
    assign data_swbit = sw[con_choice];

    serial_accum_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_clear      (clear),
        .o_con_choice (con_choice),
        .i_data_swbit (data_swbit),
        .o_acc        (acc),
        .o_carry      (carry),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] acc;
        logic              carry;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model_acc = '0;
    int                checks = 0;
    int                errors = 0;

    // Inputs are driven and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_acc = '0;
    endtask

    // Drive a start for one edge and queue the expected result of the pass.
    task automatic start_pass(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] s;
        exp_t e;
        sw = v;
        s = {1'b0, model_acc} + {1'b0, v};
        e.acc = s[DATA_W-1:0];
        e.carry = s[DATA_W];
        model_acc = s[DATA_W-1:0];
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for o_done. cyc counts edges after the start edge.
    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({acc, carry, busy, done, con_choice} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got acc=%h carry=%b busy=%b done=%b sel=%0d want all 0",
                     acc, carry, busy, done, con_choice);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || acc !== '0) begin
            errors++;
            $display("FAIL reset_release got acc=%h busy=%b done=%b want 0", acc, busy, done);
        end
    endtask

    task automatic test_basic();
        int cyc;
        bit got;
        exp_t e;
        do_clear();
        checks++;
        if (acc !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear got acc=%h carry=%b want 00/0", acc, carry);
        end
        start_pass(8'h05);
        wait_done(cyc, got);
        e = sb_q.pop_front();
        checks++;
        if (!got || cyc != 8) begin
            errors++;
            $display("FAIL basic_latency got done=%b after %0d edges want done after 8", got, cyc);
        end
        checks++;
        if (acc !== e.acc || carry !== e.carry) begin
            errors++;
            $display("FAIL basic_result got acc=%h carry=%b want %h/%b", acc, carry, e.acc, e.carry);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        bit got;
        exp_t e;
        logic [DATA_W-1:0] vals [3];
        vals[0] = 8'hFF;
        vals[1] = 8'h01;
        vals[2] = 8'h00;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            start_pass(vals[i]);
            wait_done(cyc, got);
            e = sb_q.pop_front();
            checks++;
            if (!got || acc !== e.acc || carry !== e.carry) begin
                errors++;
                $display("FAIL overflow_pass%0d got done=%b acc=%h carry=%b want 1/%h/%b",
                         i, got, acc, carry, e.acc, e.carry);
            end
            tick();
        end
    endtask

    task automatic test_con_choice();
        int cyc;
        bit got;
        exp_t e;
        checks++;
        if (con_choice !== 3'd0) begin
            errors++;
            $display("FAIL sel_idle got %0d want 0", con_choice);
        end
        start_pass(8'hA6);
        for (int i = 0; i < DATA_W; i++) begin
            checks++;
            if (con_choice !== SEL_W'(i) || busy !== 1'b1) begin
                errors++;
                $display("FAIL sel_seq step %0d got sel=%0d busy=%b want %0d/1", i, con_choice, busy, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || con_choice !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sel_done got done=%b sel=%0d busy=%b want 1/0/0", done, con_choice, busy);
        end
        e = sb_q.pop_front();
        checks++;
        if (acc !== e.acc || carry !== e.carry) begin
            errors++;
            $display("FAIL sel_result got acc=%h carry=%b want %h/%b", acc, carry, e.acc, e.carry);
        end
        tick();
    endtask

    task automatic test_ignore_mid();
        int cyc;
        bit got;
        int n;
        int dcyc;
        exp_t e;
        logic [DATA_W-1:0] acc_at;
        logic carry_at;
        do_clear();
        start_pass(8'h10);
        wait_done(cyc, got);
        void'(sb_q.pop_front());
        tick();
        start_pass(8'h22);
        n = 0;
        dcyc = 0;
        acc_at = '0;
        carry_at = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            start = (i == 3);
            clear = (i == 5);
            tick();
            if (done === 1'b1) begin
                n++;
                if (n == 1) begin
                    dcyc = i;
                    acc_at = acc;
                    carry_at = carry;
                end
            end
        end
        start = 1'b0;
        clear = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (n != 1 || dcyc != 8) begin
            errors++;
            $display("FAIL mid_done_count got %0d pulses first at %0d want 1 at 8", n, dcyc);
        end
        checks++;
        if (acc_at !== e.acc || carry_at !== e.carry) begin
            errors++;
            $display("FAIL mid_result got acc=%h carry=%b want %h/%b", acc_at, carry_at, e.acc, e.carry);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        bit got;
        exp_t e;
        start_pass(8'h5C);
        repeat (4) tick();
        checks++;
        if (con_choice !== 3'd4) begin
            errors++;
            $display("FAIL areset_setup got sel=%0d want 4", con_choice);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({acc, carry, busy, done, con_choice} !== '0) begin
            errors++;
            $display("FAIL areset_immediate got acc=%h carry=%b busy=%b done=%b sel=%0d want all 0",
                     acc, carry, busy, done, con_choice);
        end
        void'(sb_q.pop_front());
        model_acc = '0;
        tick();
        rst_n = 1'b1;
        tick();
        start_pass(8'h0A);
        wait_done(cyc, got);
        e = sb_q.pop_front();
        checks++;
        if (!got || acc !== e.acc || carry !== e.carry) begin
            errors++;
            $display("FAIL areset_after got done=%b acc=%h carry=%b want 1/%h/%b",
                     got, acc, carry, e.acc, e.carry);
        end
        tick();
    endtask

    task automatic test_clear_start();
        int cyc;
        bit got;
        do_clear();
        start_pass(8'h33);
        wait_done(cyc, got);
        void'(sb_q.pop_front());
        tick();
        checks++;
        if (acc !== 8'h33) begin
            errors++;
            $display("FAIL clrstart_setup got acc=%h want 33", acc);
        end
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        model_acc = '0;
        checks++;
        if (acc !== 8'h00 || busy !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL clrstart_clear got acc=%h busy=%b carry=%b want 00/0/0", acc, busy, carry);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || con_choice !== 3'd0) begin
            errors++;
            $display("FAIL clrstart_idle got busy=%b done=%b sel=%0d want 0/0/0", busy, done, con_choice);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_con_choice();
        test_ignore_mid();
        test_async_reset();
        test_clear_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
